instr_fetch_unit: RTL and testbench

- Producer end of the 32-bit instruction word consumed by the decode/control-extraction stage.
- Walks a PC and issues word reads to instruction memory over a req/ack handshake, with at most one read outstanding.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute, flushing stale instructions.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory read port, decode handoff, and execute redirects.
// The fetch unit uses the master modport. The memory/decode/execute side uses the slave modport.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: keeps one imem read in flight, buffers {pc, word} in a small FIFO, and flushes on redirect.
// Optional macro IFU_BYPASS_EN: when the FIFO is empty, an ack is forwarded to decode in the same cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      imem_addr_q;
  logic             imem_req_q;
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next;
  logic [CNT_W-1:0] count, count_after_pop, count_next;
  entry_t           head_q, head_next, push_entry;
  logic             ack_fetch, bypass_hit, push, pop;
  logic [31:0]      redirect_tgt, pc_inc;

  assign redirect_tgt = bus.redirect_pc & ~32'h3;
  assign pc_inc       = fetch_pc + 32'd4;

  // An ack is only accepted in REQ. Acks in DROP are discarded, and acks in IDLE are ignored.
  assign ack_fetch = (state == REQ) && bus.imem_ack && !bus.redirect_valid;

`ifdef IFU_BYPASS_EN
  assign bypass_hit = ack_fetch && (count == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign pop             = (count != '0) && bus.instr_ready;
  assign push            = ack_fetch && !(bypass_hit && bus.instr_ready);
  assign push_entry      = '{pc: fetch_pc, word: bus.imem_data};
  assign count_after_pop = count - CNT_W'(pop);
  assign count_next      = count_after_pop + CNT_W'(push);
  assign rd_ptr_next     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  // If nothing survives the pop, the incoming word becomes the new head.
  assign head_next       = (count_after_pop == '0) ? push_entry : mem[rd_ptr_next];

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = (count != '0) || bypass_hit;
  assign bus.instr       = bypass_hit ? bus.imem_data : head_q.word;
  assign bus.instr_pc    = bypass_hit ? fetch_pc      : head_q.pc;

  // NOTE: storage has no reset; count/pointers gate validity, so clearing the array would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: state uses non-blocking assignments under an async reset so every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      head_q      <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_tgt;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A read still in flight without an ack must be allowed to complete, so wait in DROP.
      if ((state != IDLE) && !bus.imem_ack) begin
        state <= DROP;
      end else begin
        state       <= REQ;
        imem_req_q  <= 1'b1;
        imem_addr_q <= redirect_tgt;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (count_next != '0) head_q <= head_next;
      case (state)
        IDLE: begin
          if (count_after_pop < DEPTH_C) begin
            state       <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            fetch_pc <= pc_inc;
            if (count_next < DEPTH_C) begin
              imem_addr_q <= pc_inc;
            end else begin
              state      <= IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state       <= REQ;
            imem_addr_q <= fetch_pc;
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirects, PC wrap, latency/bypass.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder: ack after mem_lat idle cycles of a held request; force_ack injects a stray ack.
  int          mem_lat;
  logic        mem_en;
  logic        force_ack;
  logic        use_fixed;
  logic [31:0] fixed_word;
  int          wait_cnt;
  int          ack_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.imem_ack  = force_ack || (mem_en && bus.imem_req && (wait_cnt >= mem_lat));
  assign bus.imem_data = use_fixed ? fixed_word : mem_word(bus.imem_addr);

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (bus.imem_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset          = 1'b1;
    bus.redirect_valid = 1'b0;
    #1;
    check({tag, "_req"},   32'(bus.imem_req),    32'd0);
    check({tag, "_addr"},  bus.imem_addr,        RST_PC);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"}, bus.instr,            32'd0);
    check({tag, "_pc"},    bus.instr_pc,         32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget,
                            output logic [31:0] pc, output logic [31:0] word);
    int n = 0;
    while (!bus.instr_valid && n < budget) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 32'(bus.instr_valid), 32'd1);
    pc   = bus.instr_pc;
    word = bus.instr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, word, exp_pc;
    int          base, n;

    reset              = 1'b1;
    mem_en             = 1'b1;
    mem_lat            = 0;
    force_ack          = 1'b0;
    use_fixed          = 1'b0;
    fixed_word         = 32'h0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Zero-wait streaming: one address per cycle, instr_pc trails by the fetch latency.
    do_reset("rst0");
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stream_addr%0d", i), bus.imem_addr, RST_PC + 32'(4 * i));
      check($sformatf("stream_req%0d", i), 32'(bus.imem_req), 32'd1);
      if (i == 0) begin
        check("stream_valid0", 32'(bus.instr_valid), 32'(BYP));
      end else begin
        exp_pc = BYP ? RST_PC + 32'(4 * i) : RST_PC + 32'(4 * (i - 1));
        check($sformatf("stream_valid%0d", i), 32'(bus.instr_valid), 32'd1);
        check($sformatf("stream_pc%0d", i), bus.instr_pc, exp_pc);
        check($sformatf("stream_word%0d", i), bus.instr, mem_word(exp_pc));
      end
    end

    // Back-pressure: FIFO fills after two acks, request drops, head holds; then drain and resume.
    bus.instr_ready = 1'b0;
    do_reset("rst_mid");
    base = ack_cnt;
    step();
    check("stall_addr0", bus.imem_addr, 32'h100);
    step();
    check("stall_addr1", bus.imem_addr, 32'h104);
    step();
    step();
    step();
    check("stall_acks", 32'(ack_cnt - base), 32'd2);
    check("stall_req", 32'(bus.imem_req), 32'd0);
    check("stall_valid", 32'(bus.instr_valid), 32'd1);
    check("stall_pc", bus.instr_pc, 32'h100);
    check("stall_word", bus.instr, mem_word(32'h100));
    bus.instr_ready = 1'b1;
    step();
    check("drain_addr", bus.imem_addr, 32'h108);
    check("drain_req", 32'(bus.imem_req), 32'd1);
    check("drain_pc0", bus.instr_pc, 32'h104);
    step();
    check("drain_pc1", bus.instr_pc, 32'h108);

    // Redirect with a 3-cycle memory: in-flight read completes at old address and is discarded.
    mem_lat = 3;
    do_reset("rst_drop");
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    step();
    bus.redirect_valid = 1'b0;
    check("drop_addr_hold", bus.imem_addr, 32'h100);
    check("drop_req_hold", 32'(bus.imem_req), 32'd1);
    check("drop_valid", 32'(bus.instr_valid), 32'd0);
    step();
    check("drop_old_ack", 32'(bus.imem_ack), 32'd1);
    step();
    check("drop_new_addr", bus.imem_addr, 32'h200);
    check("drop_valid2", 32'(bus.instr_valid), 32'd0);
    wait_valid("drop_first", 10, pc, word);
    check("drop_first_pc", pc, 32'h200);
    check("drop_first_word", word, mem_word(32'h200));

    // Redirect in the same cycle as an ack: that word is dropped, next request goes to the target.
    step();
    n = 0;
    while (!bus.imem_ack && n < 10) begin
      step();
      n++;
    end
    check("same_ack_seen", 32'(bus.imem_ack), 32'd1);
    check("same_ack_addr", bus.imem_addr, 32'h204);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3000_0011;
    step();
    bus.redirect_valid = 1'b0;
    check("same_addr", bus.imem_addr, 32'h3000_0010);
    check("same_req", 32'(bus.imem_req), 32'd1);
    check("same_flushed", 32'(bus.instr_valid), 32'd0);
    wait_valid("same_first", 10, pc, word);
    check("same_first_pc", pc, 32'h3000_0010);

    // PC wrap from 0xFFFF_FFFC to 0 (redirect also masks the low bits).
    mem_lat = 0;
    do_reset("rst_wrap");
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", 32'(bus.instr_valid), 32'(BYP));
    step();
    exp_pc = BYP ? 32'h0 : 32'hFFFF_FFFC;
    check("wrap_addr1", bus.imem_addr, 32'h0);
    check("wrap_pc", bus.instr_pc, exp_pc);
    check("wrap_word", bus.instr, mem_word(exp_pc));

    // Latency / bypass with a fixed word; a stray ack while IDLE after reset is ignored.
    mem_lat    = 2;
    use_fixed  = 1'b1;
    fixed_word = 32'h0000_0013;
    do_reset("rst_lat");
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    #1;
    check("idle_ack_addr", bus.imem_addr, RST_PC);
    check("idle_ack_valid", 32'(bus.instr_valid), 32'd0);
    step();
    step();
    check("lat_ack", 32'(bus.imem_ack), 32'd1);
    check("lat_valid_ack_cycle", 32'(bus.instr_valid), 32'(BYP));
`ifdef IFU_BYPASS_EN
    check("byp_instr", bus.instr, 32'h13);
    check("byp_pc", bus.instr_pc, 32'h100);
    step();
    check("byp_fifo_empty", 32'(bus.instr_valid), 32'd0);
`else
    step();
    check("lat_valid_next", 32'(bus.instr_valid), 32'd1);
    check("lat_instr", bus.instr, 32'h13);
    check("lat_pc", bus.instr_pc, 32'h100);
    step();
    check("lat_empty", 32'(bus.instr_valid), 32'd0);
    check("lat_hold_instr", bus.instr, 32'h13);
    check("lat_hold_pc", bus.instr_pc, 32'h100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
